// File: rtl/reorder_status_pkg.sv
// Shared types and helpers for the reorder status table: entry layout, default sizing
// and the (epoch, tag) -> entry index mapping.
package reorder_status_pkg;

  typedef struct packed {
    logic valid;
    logic status;
  } entry_t;

  localparam int DEFAULT_TAG_WIDTH = 6;
  localparam int DEFAULT_CB_SIZE   = 50;

  // Epoch 0 occupies the low bank, epoch 1 the high bank.
  function automatic int entry_index(input logic epoch, input int tag, input int cb_size);
    return (epoch ? cb_size : 0) + tag;
  endfunction

endpackage

// File: rtl/reorder_status_wr_arb.sv
// Combinational write arbitration: per-core tag range check, same-entry priority
// (lowest core wins) and rejection of writes whose target entry is already valid.
module reorder_status_wr_arb #(
  parameter int NUM_CORES            = 4,
  parameter int TAG_WIDTH            = 6,
  parameter int CIRCULAR_BUFFER_SIZE = 50
) (
  input  logic [NUM_CORES-1:0]           i_valids,
  input  logic [NUM_CORES*TAG_WIDTH-1:0] i_tags,
  input  logic [NUM_CORES-1:0]           i_epochs,
  input  logic [NUM_CORES-1:0]           i_tgt_valid,
  output logic [NUM_CORES-1:0]           o_accept,
  output logic                           o_dup,
  output logic                           o_range
);

  logic [NUM_CORES-1:0] w_in_range;
  logic [NUM_CORES-1:0] w_lost;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_range
      assign w_in_range[gi] = int'(i_tags[gi*TAG_WIDTH +: TAG_WIDTH]) < CIRCULAR_BUFFER_SIZE;
    end
  endgenerate

  // A core loses if any lower-indexed core posts a legal write to the same entry.
  always_comb begin
    w_lost = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      for (int j = 0; j < i; j++) begin
        if (i_valids[j] && w_in_range[j] &&
            i_tags[j*TAG_WIDTH +: TAG_WIDTH] == i_tags[i*TAG_WIDTH +: TAG_WIDTH] &&
            i_epochs[j] == i_epochs[i]) begin
          w_lost[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_accept = '0;
    o_dup    = 1'b0;
    o_range  = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (i_valids[i]) begin
        if (!w_in_range[i])                  o_range     = 1'b1;
        else if (i_tgt_valid[i] || w_lost[i]) o_dup       = 1'b1;
        else                                  o_accept[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reorder_status_table.sv
// Verdict table between the BPF cores and the reorder circular buffer; releases verdicts
// in tag order. Optional pass/drop counters are enabled by REORDER_STATUS_STATS_EN.
module reorder_status_table
  import reorder_status_pkg::*;
#(
  parameter int  NUM_CORES            = 4,
  parameter int  TAG_WIDTH            = DEFAULT_TAG_WIDTH,
  parameter int  CIRCULAR_BUFFER_SIZE = DEFAULT_CB_SIZE,
  localparam int STATUS_TABLE_SIZE    = 2 * CIRCULAR_BUFFER_SIZE,
  localparam int OCC_WIDTH            = $clog2(STATUS_TABLE_SIZE + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CORES-1:0]           wr_valids,
  input  logic [NUM_CORES*TAG_WIDTH-1:0] parallel_wr_tags,
  input  logic [NUM_CORES-1:0]           wr_epochs,
  input  logic [NUM_CORES-1:0]           wr_packets_status,
  output logic                           rd_valid,
  output logic                           rd_status,
  output logic [TAG_WIDTH-1:0]           rd_tag,
  output logic                           rd_epoch,
  input  logic                           rd_ready,
  output logic [OCC_WIDTH-1:0]           occupancy,
  output logic                           err_dup,
  output logic                           err_range,
  input  logic                           err_clr
`ifdef REORDER_STATUS_STATS_EN
  ,
  output logic [31:0]                    pass_count,
  output logic [31:0]                    drop_count
`endif
);

  localparam int IDX_W = $clog2(STATUS_TABLE_SIZE);

  entry_t               r_table [STATUS_TABLE_SIZE];
  logic [TAG_WIDTH-1:0] r_head_tag;
  logic                 r_head_epoch;
  logic [OCC_WIDTH-1:0] r_occ;
  logic                 r_err_dup;
  logic                 r_err_range;

  logic [IDX_W-1:0]     w_idx [NUM_CORES];
  logic [NUM_CORES-1:0] w_tgt_valid;
  logic [NUM_CORES-1:0] w_accept;
  logic                 w_dup;
  logic                 w_range;
  logic [IDX_W-1:0]     w_head_idx;
  logic                 w_consume;
  logic [OCC_WIDTH-1:0] w_acc_cnt;

  // Out-of-range tags are clamped to entry 0; the arbiter rejects them anyway.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_idx
      logic [TAG_WIDTH-1:0] w_tag;
      assign w_tag       = parallel_wr_tags[gi*TAG_WIDTH +: TAG_WIDTH];
      assign w_idx[gi]   = (int'(w_tag) < CIRCULAR_BUFFER_SIZE) ?
                           IDX_W'(entry_index(wr_epochs[gi], int'(w_tag), CIRCULAR_BUFFER_SIZE)) : '0;
      assign w_tgt_valid[gi] = r_table[w_idx[gi]].valid;
    end
  endgenerate

  reorder_status_wr_arb #(
    .NUM_CORES            (NUM_CORES),
    .TAG_WIDTH            (TAG_WIDTH),
    .CIRCULAR_BUFFER_SIZE (CIRCULAR_BUFFER_SIZE)
  ) u_wr_arb (
    .i_valids    (wr_valids),
    .i_tags      (parallel_wr_tags),
    .i_epochs    (wr_epochs),
    .i_tgt_valid (w_tgt_valid),
    .o_accept    (w_accept),
    .o_dup       (w_dup),
    .o_range     (w_range)
  );

  assign w_head_idx = IDX_W'(entry_index(r_head_epoch, int'(r_head_tag), CIRCULAR_BUFFER_SIZE));
  assign rd_valid   = r_table[w_head_idx].valid;
  assign rd_status  = r_table[w_head_idx].status;
  assign rd_tag     = r_head_tag;
  assign rd_epoch   = r_head_epoch;
  assign w_consume  = rd_valid & rd_ready;

  always_comb begin
    w_acc_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) w_acc_cnt = w_acc_cnt + OCC_WIDTH'(w_accept[i]);
  end

  // Accepted writes never target a valid entry, so they cannot collide with the head clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STATUS_TABLE_SIZE; k++) r_table[k] <= '0;
    end else begin
      if (w_consume) r_table[w_head_idx] <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_accept[i]) r_table[w_idx[i]] <= {1'b1, wr_packets_status[i]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head_tag   <= '0;
      r_head_epoch <= 1'b0;
      r_occ        <= '0;
      r_err_dup    <= 1'b0;
      r_err_range  <= 1'b0;
    end else begin
      if (w_consume) begin
        if (r_head_tag == TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1)) begin
          r_head_tag   <= '0;
          r_head_epoch <= ~r_head_epoch;
        end else begin
          r_head_tag <= r_head_tag + 1'b1;
        end
      end
      r_occ       <= r_occ + w_acc_cnt - OCC_WIDTH'(w_consume);
      r_err_dup   <= w_dup   | (r_err_dup   & ~err_clr);
      r_err_range <= w_range | (r_err_range & ~err_clr);
    end
  end

  assign occupancy = r_occ;
  assign err_dup   = r_err_dup;
  assign err_range = r_err_range;

`ifdef REORDER_STATUS_STATS_EN
  logic [31:0] r_pass_count;
  logic [31:0] r_drop_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pass_count <= '0;
      r_drop_count <= '0;
    end else if (w_consume) begin
      if (rd_status) r_pass_count <= r_pass_count + 1'b1;
      else           r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign pass_count = r_pass_count;
  assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_reorder_status_table.sv
// Scoreboard bench for reorder_status_table: stimulus queues expected consumes in tag order,
// a negedge monitor pops and compares on every rd_valid && rd_ready.
module tb_reorder_status_table;

  localparam int NC = 4;
  localparam int TW = 6;
  localparam int CB = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] wr_valids, wr_epochs, wr_packets_status;
  logic [NC*TW-1:0] parallel_wr_tags;
  logic          rd_valid, rd_status, rd_epoch, rd_ready;
  logic [TW-1:0] rd_tag;
  logic [6:0]    occupancy;
  logic          err_dup, err_range, err_clr;
`ifdef REORDER_STATUS_STATS_EN
  logic [31:0]   pass_count, drop_count;
`endif

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int         exp_pass = 0;
  int         exp_drop = 0;

  always #5 clk = ~clk;

  reorder_status_table #(
    .NUM_CORES            (NC),
    .TAG_WIDTH            (TW),
    .CIRCULAR_BUFFER_SIZE (CB)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .wr_valids         (wr_valids),
    .parallel_wr_tags  (parallel_wr_tags),
    .wr_epochs         (wr_epochs),
    .wr_packets_status (wr_packets_status),
    .rd_valid          (rd_valid),
    .rd_status         (rd_status),
    .rd_tag            (rd_tag),
    .rd_epoch          (rd_epoch),
    .rd_ready          (rd_ready),
    .occupancy         (occupancy),
    .err_dup           (err_dup),
    .err_range         (err_range),
    .err_clr           (err_clr)
`ifdef REORDER_STATUS_STATS_EN
    ,
    .pass_count        (pass_count),
    .drop_count        (drop_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_wr();
    wr_valids         = '0;
    parallel_wr_tags  = '0;
    wr_epochs         = '0;
    wr_packets_status = '0;
  endtask

  task automatic wr(input int core, input int tag, input logic ep, input logic st);
    wr_valids[core]                   = 1'b1;
    parallel_wr_tags[core*TW +: TW]   = TW'(tag);
    wr_epochs[core]                   = ep;
    wr_packets_status[core]           = st;
  endtask

  function automatic logic [7:0] rec(input int tag, input logic ep, input logic st);
    return {TW'(tag), ep, st};
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_queue_left", exp_q.size(), 0);
  endtask

  // Monitor: every consume must match the next queued verdict.
  always @(negedge clk) begin
    if (rst) begin
      exp_pass = 0;
      exp_drop = 0;
    end else if (rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_consume: got tag %0d epoch %0d, required no consume", rd_tag, rd_epoch);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("consume tag=%0d epoch=%0d status=%0d", rd_tag, rd_epoch, rd_status);
        check("consume_tag_epoch_status", {24'd0, rd_tag, rd_epoch, rd_status}, {24'd0, mon_exp});
        if (mon_exp[0]) exp_pass++;
        else            exp_drop++;
      end
    end
  end

  initial begin
    rst = 1'b1;
    rd_ready = 1'b0;
    err_clr = 1'b0;
    clr_wr();
    #1;
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_status", rd_status, 0);
    check("reset_rd_tag", rd_tag, 0);
    check("reset_rd_epoch", rd_epoch, 0);
    check("reset_occupancy", occupancy, 0);
    check("reset_err_dup", err_dup, 0);
    check("reset_err_range", err_range, 0);
    tick();
    tick();
    rst = 1'b0;

    // In-order single core through both epochs.
    rd_ready = 1'b1;
    for (int e = 0; e < 2; e++) begin
      for (int t = 0; t < CB; t++) begin
        clr_wr();
        wr(0, t, e[0], 1'b1);
        exp_q.push_back(rec(t, e[0], 1'b1));
        tick();
      end
    end
    clr_wr();
    tick();
    check("inorder_occupancy", occupancy, 0);
    check("inorder_head_tag", rd_tag, 0);
    check("inorder_head_epoch", rd_epoch, 0);
    check("inorder_err_dup", err_dup, 0);
    check("inorder_err_range", err_range, 0);

    // Out-of-order arrival: nothing released until tag 0 lands.
    clr_wr(); wr(0, 3, 1'b0, 1'b1); tick();
    check("ooo_wait_a", rd_valid, 0);
    clr_wr(); wr(1, 1, 1'b0, 1'b0); tick();
    check("ooo_wait_b", rd_valid, 0);
    clr_wr(); wr(2, 2, 1'b0, 1'b1); tick();
    check("ooo_wait_c", rd_valid, 0);
    exp_q.push_back(rec(0, 1'b0, 1'b0));
    exp_q.push_back(rec(1, 1'b0, 1'b0));
    exp_q.push_back(rec(2, 1'b0, 1'b1));
    exp_q.push_back(rec(3, 1'b0, 1'b1));
    clr_wr(); wr(3, 0, 1'b0, 1'b0); tick();
    check("ooo_head_valid", rd_valid, 1);
    clr_wr();
    repeat (4) tick();
    check("ooo_occupancy", occupancy, 0);
    check("ooo_head_tag", rd_tag, 4);

    // Collision, duplicate, range and clear priority with the head held at tag 4.
    rd_ready = 1'b0;
    clr_wr(); wr(0, 5, 1'b0, 1'b1); wr(2, 5, 1'b0, 1'b0); tick();
    check("collide_err_dup", err_dup, 1);
    check("collide_occupancy", occupancy, 1);
    clr_wr(); err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("collide_err_clr", err_dup, 0);
    wr(1, 7, 1'b0, 1'b0); tick();
    check("dup_first_write_ok", err_dup, 0);
    check("dup_first_occupancy", occupancy, 2);
    clr_wr(); wr(0, 7, 1'b0, 1'b1); tick();
    check("dup_rewrite_err", err_dup, 1);
    check("dup_rewrite_occupancy", occupancy, 2);
    clr_wr(); err_clr = 1'b1; tick(); err_clr = 1'b0;
    wr(0, 60, 1'b0, 1'b1); tick();
    check("range_err", err_range, 1);
    check("range_err_dup_clean", err_dup, 0);
    check("range_occupancy", occupancy, 2);
    clr_wr(); wr(3, 61, 1'b1, 1'b1); err_clr = 1'b1; tick();
    check("range_set_beats_clr", err_range, 1);
    clr_wr(); tick(); err_clr = 1'b0;
    check("range_cleared", err_range, 0);
    rd_ready = 1'b1;
    exp_q.push_back(rec(4, 1'b0, 1'b1));
    exp_q.push_back(rec(5, 1'b0, 1'b1));
    exp_q.push_back(rec(6, 1'b0, 1'b0));
    exp_q.push_back(rec(7, 1'b0, 1'b0));
    wr(0, 4, 1'b0, 1'b1); wr(1, 6, 1'b0, 1'b0); tick();
    clr_wr();
    repeat (4) tick();
    check("errblk_occupancy", occupancy, 0);
    check("errblk_head_tag", rd_tag, 8);

    // Back-pressure: fill the whole window from head (8,0), then consume with a rewrite of the freed slot.
    rd_ready = 1'b0;
    for (int c = 0; c < 25; c++) begin
      clr_wr();
      for (int j = 0; j < NC; j++) begin
        int k, pos;
        k   = c * NC + j;
        pos = 8 + k;
        wr(j, pos % CB, 1'((pos / CB) % 2), (k % 3) != 0);
        exp_q.push_back(rec(pos % CB, 1'((pos / CB) % 2), (k % 3) != 0));
      end
      tick();
    end
    clr_wr();
    check("full_occupancy", occupancy, 100);
    check("full_rd_valid", rd_valid, 1);
    check("full_head_tag", rd_tag, 8);
    rd_ready = 1'b1;
    wr(0, 8, 1'b0, 1'b0);
    tick();
    clr_wr();
    check("freed_slot_dup", err_dup, 1);
    check("freed_slot_occupancy", occupancy, 99);
    drain(200);
    check("drain_occupancy", occupancy, 0);
    check("drain_head_tag", rd_tag, 8);
    check("drain_head_epoch", rd_epoch, 0);
`ifdef REORDER_STATUS_STATS_EN
    check("stats_pass", pass_count, exp_pass);
    check("stats_drop", drop_count, exp_drop);
`endif

    // Reset mid-run with 30 pending verdicts.
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    rd_ready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      wr(k % NC, 8 + k, 1'b0, 1'b1);
      if ((k % NC) == NC - 1 || k == 29) begin
        tick();
        clr_wr();
      end
    end
    check("pending_occupancy", occupancy, 30);
    rst = 1'b1;
    #1;
    check("midrst_rd_valid", rd_valid, 0);
    check("midrst_rd_status", rd_status, 0);
    check("midrst_occupancy", occupancy, 0);
    check("midrst_rd_tag", rd_tag, 0);
    check("midrst_rd_epoch", rd_epoch, 0);
    check("midrst_err_dup", err_dup, 0);
`ifdef REORDER_STATUS_STATS_EN
    check("midrst_pass", pass_count, 0);
    check("midrst_drop", drop_count, 0);
`endif
    tick();
    tick();
    rst = 1'b0;
    rd_ready = 1'b1;
    exp_q.push_back(rec(0, 1'b0, 1'b0));
    wr(1, 0, 1'b0, 1'b0);
    tick();
    clr_wr();
    check("restart_rd_valid", rd_valid, 1);
    check("restart_head_tag", rd_tag, 0);
    tick();
    check("restart_occupancy", occupancy, 0);
    check("restart_next_tag", rd_tag, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reorder_status_table.md
# reorder_status_table

Multi-core packet verdict table between the parallel BPF cores and the reorder circular buffer. Each of `NUM_CORES` cores posts a pass/drop verdict for a packet identified by reorder tag and epoch bit. The table stores verdicts in a double-depth array, with one bank per epoch. It presents them to the circular buffer strictly in tag order through a valid/ready read port, and clears each entry when it is consumed.

## Interface

Parameters:
- `NUM_CORES`, 4: number of parallel BPF write ports.
- `TAG_WIDTH`, 6: reorder tag width.
- `CIRCULAR_BUFFER_SIZE`, 50: tags per epoch. Must be ≤ 2^TAG_WIDTH.
- `STATUS_TABLE_SIZE`, 2*CIRCULAR_BUFFER_SIZE: entry count. Fixed relation, not independently settable.
- `OCC_WIDTH`, CLOG2(STATUS_TABLE_SIZE+1): occupancy width.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `wr_valids`, in, NUM_CORES: per-core write strobe.
- `parallel_wr_tags`, in, NUM_CORES*TAG_WIDTH: per-core tag; core i at bits [i*TAG_WIDTH +: TAG_WIDTH].
- `wr_epochs`, in, NUM_CORES: per-core epoch bit.
- `wr_packets_status`, in, NUM_CORES: verdict, 1 = pass, 0 = drop.
- `rd_valid`, out, 1: entry at head is written.
- `rd_status`, out, 1: verdict at head.
- `rd_tag`, out, TAG_WIDTH: head tag.
- `rd_epoch`, out, 1: head epoch.
- `rd_ready`, in, 1: circular buffer consumes head.
- `occupancy`, out, OCC_WIDTH: number of valid entries.
- `err_dup`, out, 1: sticky; a write hit an already-valid entry, or lost same-cycle arbitration.
- `err_range`, out, 1: sticky; a write had tag ≥ CIRCULAR_BUFFER_SIZE.
- `err_clr`, in, 1: synchronous clear of both error flags.

## Operation

- Entry index = epoch*CIRCULAR_BUFFER_SIZE + tag. Each entry holds {valid, status}.
- Write acceptance, evaluated per core every cycle with `wr_valids[i]` high:
  - Tag out of range: dropped, `err_range` set.
  - Target entry valid at the edge: dropped, `err_dup` set. This holds even if the entry is consumed in the same cycle.
  - Several cores target the same entry in one cycle: lowest core index wins, losers dropped, `err_dup` set.
  - Otherwise the entry becomes {1, status}.
- Head pointer (tag, epoch) resets to (0, 0).
- `rd_valid`/`rd_status` are combinational from the head entry. `rd_tag`/`rd_epoch` are the head registers.
- Consume on `rd_valid && rd_ready`:
  - Head entry cleared.
  - Head tag increments. At CIRCULAR_BUFFER_SIZE-1 it wraps to 0 and the epoch toggles.
- `rd_ready` with `rd_valid` low has no effect. The head never skips a pending entry.
- `occupancy` += accepted writes, −1 on consume, both in the same cycle when they coincide. Maximum is STATUS_TABLE_SIZE; overflow is impossible because a write to a valid entry is never accepted.
- Error flags: set has priority over `err_clr` in the same cycle.
- No flow control on the write side. Producers must keep tags within 2*CIRCULAR_BUFFER_SIZE of the head; the table does not police this window.

## Timing

- Reset, asynchronous: all entries invalid; head (0, 0); `rd_valid` 0, `rd_status` 0, `rd_tag` 0, `rd_epoch` 0, `occupancy` 0, errors 0, stats 0.
- Reset asserted mid-operation discards all pending verdicts immediately.
- Write accepted at edge N: entry visible, and `rd_valid` high if it is at head, in cycle N+1. Latency is 1.
- Consume at edge N: the next head is presented in cycle N+1. The sustained rate is one verdict per cycle while entries are ready.
- Throughput: up to NUM_CORES writes plus 1 consume per cycle.

## Configuration

- `REORDER_STATUS_STATS_EN`:
  - Defined: adds output ports `pass_count` [31:0] and `drop_count` [31:0]. On each consume, the counter selected by `rd_status` increments, wrapping modulo 2^32. Both reset to 0 and are cleared only by `rst`.
  - Undefined: ports and counters absent. All other behaviour is identical.

## Structure

- Package `reorder_status_pkg`:
  - Entry typedef {valid, status}.
  - Default TAG_WIDTH and CIRCULAR_BUFFER_SIZE constants.
  - Index function (epoch, tag) → entry index.
- Sub-module `reorder_status_wr_arb` (combinational):
  - Per-core range check.
  - Same-entry priority resolution.
  - Produces per-core accept plus dup/range error pulses.
- Top level holds the table, the head pointer, occupancy and error flags.

## Test plan

- In-order single core: tags 0..49 epoch 0, all pass, then 0..49 epoch 1 with `rd_ready`=1 → 100 consumes in order; `rd_epoch` toggles after tag 49; `occupancy` ends 0.
- Out-of-order: cores write tags 3, 1, 2, 0 in successive cycles → `rd_valid` stays 0 until tag 0 lands, then tags 0–3 are read in 4 consecutive cycles with the correct verdicts.
- Collision: cores 0 and 2 write tag 5 epoch 0 in the same cycle with status 1 and 0 → stored status 1, `err_dup`=1, `occupancy` +1. A later `err_clr` → 0.
- Duplicate and range: rewrite valid tag 7 → dropped, `err_dup`=1. Write tag 60 → dropped, `err_range`=1. `err_clr` in the same cycle as a new error → flag stays 1.
- Back-pressure: fill all 100 entries with `rd_ready`=0 → `occupancy`=100. Then `rd_ready`=1 with a concurrent write to the just-freed slot → slot rejected as dup. Drain completes 100 consumes.
- Reset mid-run with 30 pending, stats enabled → all outputs 0 the same cycle; `pass_count`/`drop_count` 0. The head restarts at tag 0 epoch 0.
